// File: rtl/pc_seq_popcount_if.sv
// pc_seq_popcount_if: word-in / count-out valid-ready handshake bundle.
interface pc_seq_popcount_if #(parameter int CHUNKS = 8);
    localparam int W = 7 * CHUNKS;
    localparam int CW = $clog2(W + 1);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_count);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_count);
endinterface

// File: rtl/pc_seq_popcount.sv
// pc_seq_popcount: sequential popcount, one 7-bit chunk per cycle through a single 7:3 counter.
module pc_fa_7_3 (
    input  logic [6:0] a,
    output logic [2:0] count
);
    logic s1, c1, s2, c2, c3;
    // Four full adders: two first-level, one combining sums, one combining carries.
    assign s1 = a[0] ^ a[1] ^ a[2];
    assign c1 = (a[0] & a[1]) | (a[2] & (a[0] ^ a[1]));
    assign s2 = a[3] ^ a[4] ^ a[5];
    assign c2 = (a[3] & a[4]) | (a[5] & (a[3] ^ a[4]));
    assign count[0] = s1 ^ s2 ^ a[6];
    assign c3 = (s1 & s2) | (a[6] & (s1 ^ s2));
    assign count[1] = c1 ^ c2 ^ c3;
    assign count[2] = (c1 & c2) | (c3 & (c1 ^ c2));
endmodule

module pc_seq_popcount #(parameter int CHUNKS = 8) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic busy,
    pc_seq_popcount_if.slave bus
);
    localparam int W = 7 * CHUNKS;
    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(CHUNKS);
    localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, next;
    logic [W-1:0] word;
    logic [IW-1:0] idx;
    logic [CW-1:0] acc;
    logic armed;
    logic [2:0] cnt;
    logic accept;
    pc_fa_7_3 u_fa (.a(word[7*idx +: 7]), .count(cnt));
    // armed keeps in_ready low until the first edge after reset release
    assign bus.in_ready = armed && state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.out_count = acc;
    assign busy = state != IDLE;
    assign accept = bus.in_valid && bus.in_ready && !clear;
    always_comb begin
        next = state;
        if (clear) next = IDLE;
        else if (state == IDLE) next = accept ? RUN : IDLE;
        else if (state == RUN) next = idx == LAST ? DONE : RUN;
        else if (state == DONE) next = bus.out_ready ? IDLE : DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            word <= '0;
            idx <= '0;
            acc <= '0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            state <= next;
            if (accept) begin
                word <= bus.in_data;
                idx <= '0;
                acc <= '0;
            end else if (state == RUN && !clear) begin
                acc <= acc + CW'(cnt);
                idx <= idx == LAST ? idx : idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_pc_seq_popcount.sv
// tb_pc_seq_popcount: directed checks of latency, handshake, clear and reset behaviour.
module tb_pc_seq_popcount;
    logic clk, rst, clear, busy;
    int checks = 0;
    int errors = 0;
    int lat;
    pc_seq_popcount_if #(.CHUNKS(8)) bus ();
    pc_seq_popcount #(.CHUNKS(8)) dut (.clk(clk), .rst(rst), .clear(clear), .busy(busy), .bus(bus));
    initial clk = 0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [55:0] d);
        bus.in_valid = 1;
        bus.in_data = d;
        check("accept_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 0;
    endtask
    task automatic wait_done(output int l);
        l = 1;
        while (!bus.out_valid && l < 30) begin
            tick();
            l++;
        end
        check("done_timeout", bus.out_valid, 1);
    endtask
    initial begin
        rst = 1; clear = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        tick(); tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", bus.out_count, 0);
        rst = 0;
        bus.in_valid = 1; bus.in_data = '1;
        check("pre_edge_in_ready", bus.in_ready, 0);
        tick();
        check("post_rst_in_ready", bus.in_ready, 1);
        check("no_accept_in_rst", busy, 0);
        bus.in_valid = 0;
        // all ones: latency and full count
        bus.out_ready = 1;
        send(56'hFF_FFFF_FFFF_FFFF);
        wait_done(lat);
        check("latency_all_ones", lat, 9);
        check("count_all_ones", bus.out_count, 56);
        check("done_in_ready", bus.in_ready, 0);
        check("done_busy", busy, 1);
        tick();
        check("ready_after_hs1", bus.in_ready, 1);
        check("valid_after_hs1", bus.out_valid, 0);
        // zero then alternating bits, back to back
        send(56'h0);
        wait_done(lat);
        check("count_zero", bus.out_count, 0);
        check("hs_in_ready_low", bus.in_ready, 0);
        tick();
        check("ready_after_hs2", bus.in_ready, 1);
        send(56'h55_5555_5555_5555);
        wait_done(lat);
        check("latency_55", lat, 9);
        check("count_55", bus.out_count, 28);
        tick();
        check("ready_after_hs3", bus.in_ready, 1);
        // data changes after acceptance must not matter
        send(56'hFE_0000_0000_0000);
        bus.in_data = '1;
        wait_done(lat);
        check("count_chunk7", bus.out_count, 7);
        tick();
        // backpressure in DONE
        bus.out_ready = 0;
        send(56'h7F_7F7F_0000_0003);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_data = 56'h1;
            check("bp_valid", bus.out_valid, 1);
            check("bp_count", bus.out_count, 23);
            check("bp_in_ready", bus.in_ready, 0);
            tick();
        end
        bus.in_valid = 0;
        check("bp_valid_end", bus.out_valid, 1);
        check("bp_count_end", bus.out_count, 23);
        bus.out_ready = 1;
        tick();
        check("bp_released", bus.in_ready, 1);
        check("idle_holds_count", bus.out_count, 23);
        // clear mid-RUN
        send(56'h12_3456_789A_BCDE);
        tick(); tick();
        clear = 1;
        tick();
        clear = 0;
        check("clear_busy", busy, 0);
        check("clear_in_ready", bus.in_ready, 1);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) lat++;
            tick();
        end
        check("clear_no_valid", lat, 0);
        send(56'hFF_FFFF_FFFF_FFFF);
        wait_done(lat);
        check("post_clear_count", bus.out_count, 56);
        tick();
        // async reset mid-RUN
        send(56'hFF_0000_0000_00FF);
        tick(); tick(); tick();
        rst = 1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 0);
        check("arst_count", bus.out_count, 0);
        tick();
        check("arst_hold_busy", busy, 0);
        rst = 0;
        tick();
        check("arst_rel_valid", bus.out_valid, 0);
        check("arst_rel_ready", bus.in_ready, 1);
        send(56'h1FFF);
        wait_done(lat);
        check("post_rst_latency", lat, 9);
        check("post_rst_count", bus.out_count, 13);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_seq_popcount.md
PC_SEQ_POPCOUNT -- requirements
Module: pc_seq_popcount

Interface
REQ-001 Parameter: CHUNKS, default 8, number of 7-bit chunks per input word; legal range 2..16.
REQ-002 Derived width: W = 7*CHUNKS; CW = $clog2(W+1) (6 at default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 clear  input  1  synchronous abort; discards any word in flight.
REQ-006 in_valid  input  1  in_data holds a word to count.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  W  word whose set bits are counted; chunk k = in_data[7k+6:7k].
REQ-009 out_valid  output  1  out_count holds a finished result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_count  output  CW  number of 1 bits in the accepted word.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 Exactly one pc_fa_7_3 instance, time-shared across all chunks; no other adder tree for chunk counting.
REQ-014 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready&&!clear, latch in_data, idx<=0, acc<=0, go to RUN.
REQ-016 in_data is sampled only at the acceptance edge; later changes have no effect on the result.
REQ-017 RUN: pc_fa_7_3 input = latched chunk idx; each edge acc<=acc+count_out (zero-extended to CW), idx<=idx+1.
REQ-018 RUN lasts exactly CHUNKS cycles; on the edge that adds chunk CHUNKS-1, go to DONE.
REQ-019 Latency: out_valid first high CHUNKS+1 cycles after the acceptance edge (the cycle after the last RUN cycle).
REQ-020 acc is CW bits and never overflows (max sum = W); no saturation logic.
REQ-021 DONE: out_valid=1, out_count=acc, both held stable until handshake.
REQ-022 On out_valid&&out_ready in DONE, go to IDLE; in_ready stays 0 in that cycle (no same-cycle re-accept).
REQ-023 Peak throughput: one word per CHUNKS+2 cycles.
REQ-024 in_ready=0 in RUN and DONE; in_valid is ignored there.
REQ-025 clear=1 in any state: next state IDLE, out_valid low next cycle, result discarded; clear wins over in_valid and out_ready in the same cycle.
REQ-026 out_count outside DONE: holds the last acc value; meaningful only when out_valid=1.
REQ-027 idx wraps never: width $clog2(CHUNKS), and only the FSM transition controls termination.

Reset
REQ-028 While rst=1: state IDLE, idx=0, acc=0, out_count=0, out_valid=0, busy=0, in_ready=0.
REQ-029 First edge after rst falls: in_ready=1; no word is accepted while rst is high.
REQ-030 rst asserted mid-RUN or in DONE aborts immediately (asynchronously); no result is emitted for that word.

Verification
REQ-031 in_data=56'hFF_FFFF_FFFF_FFFF accepted, out_ready=1 -> out_valid rises 9 cycles after acceptance, out_count=56.
REQ-032 in_data=0 -> out_count=0; then in_data=56'h55_5555_5555_5555 -> out_count=28; in_ready returns 1 exactly one cycle after each output handshake.
REQ-033 Only chunk 7 = 7'h7F, rest zero, in_data changed to all-ones after acceptance -> out_count=7.
REQ-034 out_ready held low 5 cycles in DONE -> out_valid and out_count (e.g. 23) stable all 5 cycles; in_valid pulses ignored.
REQ-035 clear pulsed at RUN cycle 3 -> IDLE next cycle, out_valid never rises; next word (all-ones) -> out_count=56.
REQ-036 rst asserted at RUN cycle 4 -> all outputs at reset values during rst; after release, word with 13 set bits -> out_count=13.
